// File: rtl/ni_pkg.sv
// Shared types and helpers for the NI tester FIFO slice.
package ni_pkg;

    localparam int NI_DATA_WIDTH = 8;

    typedef logic [NI_DATA_WIDTH-1:0] ni_word_t;

    // Level counts 0..DEPTH inclusive, so it needs one bit more than a pointer.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ni_fifo_if.sv
// Clock/reset bundle and the FIFO handshake bundle between the NI tester and the network interface.
interface clk_rst_if;
    logic clk;
    logic rst_n;

    modport source (output clk, output rst_n);
    modport sink   (input clk, input rst_n);
endinterface

interface ni_fifo_if
    import ni_pkg::*;
#(
    parameter int DATA_WIDTH = NI_DATA_WIDTH,
    parameter int DEPTH      = 16
);
    logic                          flush;
    logic                          wr_valid;
    logic                          wr_ready;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic                          rd_valid;
    logic                          rd_ready;
    logic [DATA_WIDTH-1:0]         rd_data;
    logic [level_width(DEPTH)-1:0] level;
    logic                          almost_full;
    logic                          almost_empty;
    logic                          overflow_err;
    logic                          underflow_err;

    modport master (
        output flush, wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, level,
        input  almost_full, almost_empty, overflow_err, underflow_err
    );

    modport slave (
        input  flush, wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, level,
        output almost_full, almost_empty, overflow_err, underflow_err
    );
endinterface

// File: rtl/ni_fifo_mem.sv
// Simple dual-port register array: clocked write port, asynchronous read port.
module ni_fifo_mem
    import ni_pkg::*;
#(
    parameter int DATA_WIDTH = NI_DATA_WIDTH,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = $clog2(DEPTH)
)(
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; validity is tracked by the level in the parent.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ni_fifo.sv
// First-word-fall-through FIFO between the NI tester and the network interface.
module ni_fifo
    import ni_pkg::*;
#(
    parameter int DATA_WIDTH    = NI_DATA_WIDTH,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
)(
    clk_rst_if.sink  clk_if,
    ni_fifo_if.slave fifo_if
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_width(DEPTH);

    localparam logic [LVL_W-1:0] FULL_LEVEL   = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AFULL_LEVEL  = LVL_W'(AFULL_THRESH);
    localparam logic [LVL_W-1:0] AEMPTY_LEVEL = LVL_W'(AEMPTY_THRESH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("ni_fifo: DEPTH must be a power of two and at least 2");
        end
        if (!(AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH <= DEPTH)) begin : g_bad_thresh
            $error("ni_fifo: thresholds must satisfy AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
        end
    endgenerate

    logic                  clk;
    logic                  rst_n;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      level;
    logic                  overflow_err;
    logic                  underflow_err;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    assign clk   = clk_if.clk;
    assign rst_n = clk_if.rst_n;

    // Full/empty come from the level register so the ready/valid outputs never see rd_ready or wr_valid.
    assign full  = (level == FULL_LEVEL);
    assign empty = (level == '0);
    assign push  = fifo_if.wr_valid & ~full;
    assign pop   = fifo_if.rd_ready & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (fifo_if.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // Error flags are sticky until reset; flush leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (fifo_if.wr_valid && full) begin
                overflow_err <= 1'b1;
            end
            if (fifo_if.rd_ready && empty) begin
                underflow_err <= 1'b1;
            end
        end
    end

    ni_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push & ~fifo_if.flush),
        .wr_addr (wr_ptr),
        .wr_data (fifo_if.wr_data),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd_data)
    );

    // Gate the head word so unwritten or stale storage never shows while empty.
    assign fifo_if.rd_data       = empty ? '0 : mem_rd_data;
    assign fifo_if.rd_valid      = ~empty;
    assign fifo_if.wr_ready      = ~full;
    assign fifo_if.level         = level;
    assign fifo_if.almost_full   = (level >= AFULL_LEVEL);
    assign fifo_if.almost_empty  = (level <= AEMPTY_LEVEL);
    assign fifo_if.overflow_err  = overflow_err;
    assign fifo_if.underflow_err = underflow_err;

endmodule

// File: tb/tb_ni_fifo.sv
// Self-checking bench for ni_fifo against a queue-based reference model.
module tb_ni_fifo;
    import ni_pkg::*;

    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    clk_rst_if cr ();
    ni_fifo_if #(.DATA_WIDTH(NI_DATA_WIDTH), .DEPTH(DEPTH)) fif ();

    ni_fifo #(
        .DATA_WIDTH    (NI_DATA_WIDTH),
        .DEPTH         (DEPTH),
        .AFULL_THRESH  (AF),
        .AEMPTY_THRESH (AE)
    ) dut (
        .clk_if  (cr.sink),
        .fifo_if (fif.slave)
    );

    int       checks   = 0;
    int       failures = 0;
    ni_word_t model_q[$];
    bit       model_ovf = 1'b0;
    bit       model_udf = 1'b0;

    initial cr.clk = 1'b0;
    always #5 cr.clk = ~cr.clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Expected outputs follow directly from the model's occupancy and head word.
    task automatic checkAll(input string tag);
        int       n;
        ni_word_t head;
        n    = model_q.size();
        head = (n > 0) ? model_q[0] : '0;
        checkOutput({tag, " level"},         32'(fif.level),         32'(n));
        checkOutput({tag, " wr_ready"},      32'(fif.wr_ready),      32'(n != DEPTH));
        checkOutput({tag, " rd_valid"},      32'(fif.rd_valid),      32'(n != 0));
        checkOutput({tag, " rd_data"},       32'(fif.rd_data),       32'(head));
        checkOutput({tag, " almost_full"},   32'(fif.almost_full),   32'(n >= AF));
        checkOutput({tag, " almost_empty"},  32'(fif.almost_empty),  32'(n <= AE));
        checkOutput({tag, " overflow_err"},  32'(fif.overflow_err),  32'(model_ovf));
        checkOutput({tag, " underflow_err"}, 32'(fif.underflow_err), 32'(model_udf));
    endtask

    task automatic applyStimulus(input bit wv, input ni_word_t wd, input bit rr, input bit fl, input string tag);
        int n;
        bit do_push;
        bit do_pop;
        fif.wr_valid = wv;
        fif.wr_data  = wd;
        fif.rd_ready = rr;
        fif.flush    = fl;
        n       = model_q.size();
        do_push = wv && (n < DEPTH);
        do_pop  = rr && (n > 0);
        @(posedge cr.clk);
        if (wv && n == DEPTH) model_ovf = 1'b1;
        if (rr && n == 0)     model_udf = 1'b1;
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(wd);
        end
        #1;
        fif.wr_valid = 1'b0;
        fif.rd_ready = 1'b0;
        fif.flush    = 1'b0;
        checkAll(tag);
    endtask

    task automatic setLevel(input int target, input string tag);
        while (model_q.size() < target) applyStimulus(1'b1, ni_word_t'($urandom), 1'b0, 1'b0, tag);
        while (model_q.size() > target) applyStimulus(1'b0, '0, 1'b1, 1'b0, tag);
    endtask

    initial begin
        fif.flush    = 1'b0;
        fif.wr_valid = 1'b0;
        fif.wr_data  = '0;
        fif.rd_ready = 1'b0;
        cr.rst_n     = 1'b0;
        repeat (2) @(posedge cr.clk);
        #1;
        checkAll("reset");
        cr.rst_n = 1'b1;

        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, "push1");
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, "push2");
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, "push3");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "hold");
        checkOutput("head_hold", 32'(fif.rd_data), 32'h11);
        setLevel(0, "drain3");

        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, ni_word_t'(i), 1'b0, 1'b0, "fill");
        checkOutput("full_wr_ready", 32'(fif.wr_ready), 32'h0);
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, "overflow");
        checkOutput("overflow_flag", 32'(fif.overflow_err), 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("drain_order", 32'(fif.rd_data), 32'(i));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "drain");
        end

        setLevel(DEPTH, "refill");
        applyStimulus(1'b1, ni_word_t'($urandom), 1'b1, 1'b0, "full_push_pop");
        checkOutput("full_push_pop_level", 32'(fif.level), 32'(DEPTH - 1));

        setLevel(5, "to5");
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, ni_word_t'(8'h40 + i), 1'b1, 1'b0, "stream");

        setLevel(7, "to7");
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b1, "flush");
        applyStimulus(1'b1, 8'h66, 1'b0, 1'b0, "post_flush");
        checkOutput("post_flush_head", 32'(fif.rd_data), 32'h66);

        setLevel(0, "to0");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "underflow");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, "flush_keeps_err");
        checkOutput("underflow_sticky", 32'(fif.underflow_err), 32'h1);

        // Write-heavy then read-heavy so random traffic reaches both full and empty.
        for (int i = 0; i < 300; i++) begin
            if (i < 150)
                applyStimulus($urandom_range(0, 3) != 0, ni_word_t'($urandom),
                              $urandom_range(0, 2) == 0, $urandom_range(0, 47) == 0, "random");
            else
                applyStimulus($urandom_range(0, 2) == 0, ni_word_t'($urandom),
                              $urandom_range(0, 3) != 0, $urandom_range(0, 47) == 0, "random");
        end

        setLevel(9, "to9");
        fif.wr_valid = 1'b1;
        fif.wr_data  = ni_word_t'($urandom);
        #3;
        cr.rst_n = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        model_udf = 1'b0;
        #1;
        checkAll("async_reset");
        fif.wr_valid = 1'b0;
        repeat (2) @(posedge cr.clk);
        #1;
        checkAll("reset_hold");
        cr.rst_n = 1'b1;
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0, "post_reset");
        checkOutput("post_reset_head", 32'(fif.rd_data), 32'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
